// File: rtl/conv1d_pool_pack.sv
// conv1d_pool_pack: max-pools every 2^k signed results, packs the pooled
// bytes little-endian into words and buffers them in a show-ahead FIFO.
// Optional macro CONV_POOL_AVG_EN adds average pooling (cfg_avg).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cfg_we, cfg_pool_log2 window config, honoured only while idle
//   cfg_avg               average-pool select (CONV_POOL_AVG_EN only)
//   flush                 close partial window and partial word
//   in_valid/in_ready/in_data     result input handshake
//   out_valid/out_ready/out_data  packed word output (reads 0 when empty)
//   out_count             FIFO occupancy
//   busy                  partial data pending or flush in progress
module conv1d_pool_pack #(
  parameter int unsigned BYTE_SIZE  = 8,
  parameter int unsigned INT32_SIZE = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_we,
  input  logic [1:0]                  cfg_pool_log2,
`ifdef CONV_POOL_AVG_EN
  input  logic                        cfg_avg,
`endif
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BYTE_SIZE-1:0]        in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INT32_SIZE-1:0]       out_data,
  output logic [$clog2(FIFO_DEPTH):0] out_count,
  output logic                        busy
);

  localparam int unsigned NB = INT32_SIZE / BYTE_SIZE;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
`ifdef CONV_POOL_AVG_EN
  localparam int unsigned SW = BYTE_SIZE + 2;
`else
  localparam int unsigned SW = BYTE_SIZE;
`endif

  typedef enum logic [1:0] {RUN, FL_POOL, FL_PACK} state_t;

  state_t                 r_state, w_state_next;
  logic [1:0]             r_log2;
`ifdef CONV_POOL_AVG_EN
  logic                   r_avg;
`endif
  logic [2:0]             r_cnt;
  logic signed [SW-1:0]   r_acc;
  logic [INT32_SIZE-1:0]  r_word;
  logic [IW-1:0]          r_idx;
  logic [INT32_SIZE-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr, r_rd;
  logic [CW-1:0]          r_count;

  logic [1:0]             w_eff;
  logic [2:0]             w_win, w_cnt_inc, w_cnt_next;
  logic signed [SW-1:0]   w_in_ext, w_acc_next, w_src;
  logic [BYTE_SIZE-1:0]   w_byte;
  logic                   w_accept, w_emit, w_push, w_pop, w_full, w_pool_stall;
  logic [INT32_SIZE-1:0]  w_word_next, w_push_data;
  logic [IW-1:0]          w_idx_next;

  // log2 value 3 behaves as 2
  assign w_eff     = (r_log2 == 2'd3) ? 2'd2 : r_log2;
  assign w_win     = 3'd1 << w_eff;
  assign w_cnt_inc = r_cnt + 3'd1;
  assign w_in_ext  = SW'($signed(in_data));

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = out_ready && (r_count != '0);
  assign w_accept  = in_valid && in_ready;

  assign in_ready  = (r_state == RUN) && !w_full;
  assign out_valid = (r_count != '0);
  assign out_data  = (r_count != '0) ? r_mem[r_rd] : '0;
  assign out_count = r_count;
  assign busy      = (r_cnt != '0) || (r_idx != '0) || (r_state != RUN);

  // A flushed partial window that completes the word needs a free FIFO slot
  assign w_pool_stall = (r_state == FL_POOL) && (r_cnt != '0) &&
                        (r_idx == IW'(NB - 1)) && w_full;

  always_comb begin
`ifdef CONV_POOL_AVG_EN
    if (r_avg)
      w_acc_next = (r_cnt == '0) ? w_in_ext : (r_acc + w_in_ext);
    else
`endif
      w_acc_next = ((r_cnt == '0) || (w_in_ext > r_acc)) ? w_in_ext : r_acc;
  end

  always_comb begin
    w_cnt_next = r_cnt;
    w_emit     = 1'b0;
    w_src      = r_acc;
    if (w_accept) begin
      w_src = w_acc_next;
      if (w_cnt_inc == w_win) begin
        w_emit     = 1'b1;
        w_cnt_next = '0;
      end else begin
        w_cnt_next = w_cnt_inc;
      end
    end else if ((r_state == FL_POOL) && (r_cnt != '0) && !w_pool_stall) begin
      w_emit     = 1'b1;
      w_cnt_next = '0;
    end
  end

  // Average mode shifts by the configured log2 even for a partial window
  always_comb begin
`ifdef CONV_POOL_AVG_EN
    if (r_avg)
      w_byte = BYTE_SIZE'(w_src >>> w_eff);
    else
`endif
      w_byte = BYTE_SIZE'(w_src);
  end

  always_comb begin
    w_word_next = r_word;
    w_idx_next  = r_idx;
    w_push      = 1'b0;
    w_push_data = r_word;
    if (w_emit) begin
      w_word_next[BYTE_SIZE*r_idx +: BYTE_SIZE] = w_byte;
      if (r_idx == IW'(NB - 1)) begin
        w_push      = 1'b1;
        w_push_data = w_word_next;
        w_word_next = '0;
        w_idx_next  = '0;
      end else begin
        w_idx_next = r_idx + 1'b1;
      end
    end else if ((r_state == FL_PACK) && (r_idx != '0) && !w_full) begin
      // word register is cleared after every push, so unused bytes read 0
      w_push      = 1'b1;
      w_push_data = r_word;
      w_word_next = '0;
      w_idx_next  = '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (flush) w_state_next = FL_POOL;
      FL_POOL: if (!w_pool_stall) w_state_next = FL_PACK;
      FL_PACK: if ((r_idx == '0) || !w_full) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_log2  <= '0;
`ifdef CONV_POOL_AVG_EN
      r_avg   <= 1'b0;
`endif
      r_cnt   <= '0;
      r_acc   <= '0;
      r_word  <= '0;
      r_idx   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (cfg_we && !busy) begin
        r_log2 <= cfg_pool_log2;
`ifdef CONV_POOL_AVG_EN
        r_avg  <= cfg_avg;
`endif
      end
      if (w_accept) r_acc <= w_acc_next;
      r_cnt  <= w_cnt_next;
      r_word <= w_word_next;
      r_idx  <= w_idx_next;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_push_data;
  end

endmodule

// File: doc/conv1d_pool_pack.md
# conv1d_pool_pack

Downstream stage of the `conv1d` CFU datapath. It accepts one signed int8 quantized conv result per handshake and reduces every 2^k consecutive results with max pooling. It packs the pooled bytes little-endian into 32-bit words and buffers them in an output FIFO, which the CPU-side command logic drains one word per read. This cuts CPU result reads by a factor of 4·2^k.

## Interface
- `BYTE_SIZE`, default 8: result width.
- `INT32_SIZE`, default 32: packed word width.
- `FIFO_DEPTH`, default 16: output FIFO depth in words. Must be a power of 2.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  config write strobe. Honoured only when `busy`=0; ignored otherwise.
- `cfg_pool_log2`  in  2  pool window = 2^value. Value 3 is treated as 2.
- `cfg_avg`  in  1  selects average pooling. Only present with `CONV_POOL_AVG_EN`.
- `flush`  in  1  single-cycle pulse: close the partial window and the partial word.
- `in_valid`  in  1  input result valid.
- `in_ready`  out  1  stage can accept.
- `in_data`  in  8  signed quantized result.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  pop the head word.
- `out_data`  out  32  head word (show-ahead). Reads 0 when the FIFO is empty.
- `out_count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `busy`  out  1  high when pool_cnt≠0, byte_idx≠0, or state≠RUN.

## Operation
- Pool stage, on each accept (`in_valid && in_ready`):
  - If pool_cnt==0: pool_acc = in_data.
  - Otherwise: pool_acc = signed max(pool_acc, in_data).
  - pool_cnt increments. When it reaches 2^pool_log2, the pooled byte is emitted and pool_cnt returns to 0.
- Packer:
  - Each emitted byte is written to word[8·byte_idx +: 8], then byte_idx increments.
  - When byte_idx==3, the completed word is pushed to the FIFO and byte_idx wraps to 0.
  - Byte 0 is the earliest result.
- `in_ready` = (state==RUN) && (out_count < FIFO_DEPTH).
- FSM states:
  - RUN: normal accept. On `flush`, go to FL_POOL.
  - FL_POOL: if pool_cnt>0, emit pool_acc as a byte with a partial window; otherwise nothing. Next state is FL_PACK.
  - FL_PACK: if byte_idx>0, push the word with unused upper bytes zero, once the FIFO is not full; stall here while it is full. If byte_idx==0, nothing is pushed. Then return to RUN.
- A `flush` with no pending data takes 2 cycles and pushes nothing.
- A `flush` on the same cycle as an accept: the accept is processed first, then the flush begins.
- `cfg_we` while `busy`: ignored, and the previous window is kept.
- A pop while empty is ignored.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `out_count`=0, `busy`=0.
  - pool_log2=0, state=RUN.
  - FIFO pointers 0; word register and pool state cleared.
- Reset asserted mid-operation discards all partial and buffered data immediately.
- Latency: the accept that completes a word makes `out_valid` high on the next cycle, and `out_count` updates the same cycle.
- Simultaneous push and pop are allowed and leave `out_count` unchanged.
- Push while full cannot occur, because `in_ready` is low when full.
- Sustained throughput is one result per cycle while the FIFO is not full.
- Flush adds 2 cycles, plus any FIFO-full stall in FL_PACK.

## Configuration
- Macro `CONV_POOL_AVG_EN`.
- When defined:
  - `cfg_avg` exists and is latched on `cfg_we`.
  - In average mode, the pool stage keeps a 10-bit signed sum.
  - The emitted byte is sum >>> pool_log2, an arithmetic shift that floors toward −∞.
  - A partial window on flush is shifted by the configured log2, not by the actual count.
- When undefined: the port is absent and the stage does max pooling only.

## Test plan
- Pool 1: feed 0x01, 0x02, 0xFF, 0x80 → one word 0x80FF0201; `out_valid` rises 1 cycle after the 4th accept.
- Pool 4 (log2=2): feed −5, 3, 7, −128, then 4×10, 4×−1, 4×0 → word 0x00FF0A07.
- Pool 1: feed 5 bytes 0x11..0x15, then pulse `flush` → words 0x14131211 and 0x00000015. After the flush, `busy`=0 and `in_ready`=1.
- Backpressure: hold `out_ready`=0 and feed 64 bytes with pool 1 → `out_count`=16 and `in_ready`=0. Pop one word → `in_ready`=1 on the next cycle, and the FIFO order is preserved.
- Reset mid-operation: after 6 accepts, pulse `rst_n` low asynchronously → all outputs return to their reset values. A `cfg_we` issued with 2 pending bytes is ignored, and pool_log2 stays unchanged.
- Average mode (`CONV_POOL_AVG_EN`, log2=1): feed 3, 4, −3, −4, 127, 127, −128, −128 → word 0x807FFC03.
